// File: rtl/song_memory_bank.sv
// Multi-slot song store: RECORD appends words to the selected slot, and the play
// states stream the slot back one word per read request.
module song_memory_bank #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH_BIT  = 8,
    parameter int SONG_BIT   = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [1:0]            current_state,
    input  logic [SONG_BIT-1:0]   song_sel,
    input  logic                  write_en,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  clear,
    input  logic                  read_en,
    input  logic                  read_rst,
    input  logic                  loop_en,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  output_ready,
    output logic                  song_done,
    output logic [DEPTH_BIT:0]    duration,
    output logic                  full
);

    localparam int SONGS = 1 << SONG_BIT;
    localparam int DEPTH = 1 << DEPTH_BIT;

    localparam logic [1:0] MODE_RECORD = 2'b11;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_END   = 2'd2;

    logic [DATA_WIDTH-1:0]        mem [SONGS*DEPTH];
    logic [DEPTH_BIT:0]           len [SONGS];
    logic [DEPTH_BIT:0]           sel_len;
    logic [DEPTH_BIT:0]           rd_ptr;
    logic [SONG_BIT-1:0]          sel_q;
    logic [1:0]                   rd_state;
    logic [DATA_WIDTH-1:0]        rd_data;
    logic [DATA_WIDTH-1:0]        data_q;
    logic [SONG_BIT+DEPTH_BIT-1:0] wr_addr;
    logic [SONG_BIT+DEPTH_BIT-1:0] rd_addr;
    logic                         recording;
    logic                         rewind;
    logic                         do_write;
    logic                         accept;
    logic                         last_word;

    assign sel_len   = len[song_sel];
    assign duration  = sel_len;
    // A slot never holds more than DEPTH words, so the length MSB alone means full.
    assign full      = sel_len[DEPTH_BIT];
    assign recording = (current_state == MODE_RECORD);
    assign do_write  = !rst && recording && !clear && write_en && !full;
    assign wr_addr   = {song_sel, sel_len[DEPTH_BIT-1:0]};
    assign rd_addr   = {song_sel, rd_ptr[DEPTH_BIT-1:0]};
    assign rewind    = read_rst || (song_sel != sel_q) || recording;
    assign accept    = (rd_state == ST_IDLE) && !rewind && read_en && (rd_ptr < sel_len);
    assign last_word = (rd_ptr == sel_len - (DEPTH_BIT+1)'(1));
    assign data_out  = recording ? '0 : data_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < SONGS; i++) begin
                len[i] <= '0;
            end
        end else if (recording) begin
            if (clear) begin
                len[song_sel] <= '0;
            end else if (write_en && !full) begin
                len[song_sel] <= sel_len + (DEPTH_BIT+1)'(1);
            end
        end
    end

    // Storage is left out of reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (do_write) begin
            mem[wr_addr] <= data_in;
        end
        if (accept) begin
            rd_data <= mem[rd_addr];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_state     <= ST_IDLE;
            rd_ptr       <= '0;
            sel_q        <= '0;
            data_q       <= '0;
            output_ready <= 1'b0;
            song_done    <= 1'b0;
        end else begin
            sel_q        <= song_sel;
            output_ready <= 1'b0;
            song_done    <= 1'b0;
            if (rewind) begin
                rd_state <= ST_IDLE;
                rd_ptr   <= '0;
            end else begin
                case (rd_state)
                    ST_IDLE: begin
                        if (accept) begin
                            rd_state <= ST_FETCH;
                        end
                    end
                    ST_FETCH: begin
                        output_ready <= 1'b1;
                        data_q       <= rd_data;
                        song_done    <= last_word;
                        if (last_word && loop_en) begin
                            rd_ptr   <= '0;
                            rd_state <= ST_IDLE;
                        end else begin
                            rd_ptr   <= rd_ptr + (DEPTH_BIT+1)'(1);
                            rd_state <= last_word ? ST_END : ST_IDLE;
                        end
                    end
                    ST_END: begin
                        rd_state <= ST_END;
                    end
                    default: begin
                        rd_state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_song_memory_bank.sv
// Scoreboard bench for song_memory_bank: a song-level reference model predicts every
// read strobe, and a monitor compares what the DUT presents against those predictions.
module tb_song_memory_bank;

    localparam int DW    = 8;
    localparam int DB    = 2;
    localparam int SB    = 2;
    localparam int DEPTH = 1 << DB;
    localparam int SONGS = 1 << SB;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [1:0]    current_state = 2'b00;
    logic [SB-1:0] song_sel = '0;
    logic          write_en = 1'b0;
    logic [DW-1:0] data_in = '0;
    logic          clear = 1'b0;
    logic          read_en = 1'b0;
    logic          read_rst = 1'b0;
    logic          loop_en = 1'b0;
    logic [DW-1:0] data_out;
    logic          output_ready;
    logic          song_done;
    logic [DB:0]   duration;
    logic          full;

    always #5 clk = ~clk;

    song_memory_bank #(.DATA_WIDTH(DW), .DEPTH_BIT(DB), .SONG_BIT(SB)) dut (
        .clk(clk), .rst(rst), .current_state(current_state), .song_sel(song_sel),
        .write_en(write_en), .data_in(data_in), .clear(clear), .read_en(read_en),
        .read_rst(read_rst), .loop_en(loop_en), .data_out(data_out),
        .output_ready(output_ready), .song_done(song_done), .duration(duration), .full(full)
    );

    typedef struct {
        logic [DW-1:0] data;
        logic          done;
        int            due;
    } exp_t;

    exp_t          exp_q[$];
    exp_t          mon_e;
    logic [DW-1:0] obs_data[$];
    logic          obs_done[$];

    // Song-level model: slot contents, playback position and whether a word is in flight.
    logic [DW-1:0] m_words [SONGS][DEPTH];
    int            m_len [SONGS];
    int            m_ptr = 0;
    bit            m_busy = 0;
    bit            m_finished = 0;
    int            m_last_sel = 0;
    logic [DW-1:0] m_hold = '0;
    int            edge_count = 0;
    bit            started = 0;

    int checks = 0;
    int fails = 0;

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got %0d, expected %0d (edge %0d)", name, actual, expected, edge_count);
        end
    endtask

    task automatic model_edge();
        int  len;
        bit  rew;
        edge_count++;
        if (rst) begin
            for (int s = 0; s < SONGS; s++) m_len[s] = 0;
            m_ptr      = 0;
            m_busy     = 0;
            m_finished = 0;
            m_last_sel = 0;
            m_hold     = '0;
            started    = 1;
            return;
        end
        len = m_len[song_sel];
        rew = read_rst || (int'(song_sel) != m_last_sel) || (current_state == 2'b11);
        if (rew) begin
            m_ptr      = 0;
            m_busy     = 0;
            m_finished = 0;
        end else if (m_busy) begin
            exp_t e;
            e.data = m_words[song_sel][m_ptr];
            e.done = (m_ptr == len - 1);
            e.due  = edge_count;
            exp_q.push_back(e);
            m_hold = e.data;
            m_busy = 0;
            if (e.done) begin
                if (loop_en) m_ptr = 0;
                else begin
                    m_finished = 1;
                    m_ptr      = len;
                end
            end else begin
                m_ptr++;
            end
        end else if (!m_finished && read_en && m_ptr < len) begin
            m_busy = 1;
        end
        m_last_sel = int'(song_sel);
        if (current_state == 2'b11) begin
            if (clear) m_len[song_sel] = 0;
            else if (write_en && m_len[song_sel] < DEPTH) begin
                m_words[song_sel][m_len[song_sel]] = data_in;
                m_len[song_sel]++;
            end
        end
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic apply_stimulus(input logic [1:0] st, input logic [SB-1:0] sel, input logic we,
                                  input logic [DW-1:0] din, input logic clr, input logic re, input logic rr);
        current_state = st;
        song_sel      = sel;
        write_en      = we;
        data_in       = din;
        clear         = clr;
        read_en       = re;
        read_rst      = rr;
        step();
    endtask

    task automatic read_once(input logic [SB-1:0] sel);
        apply_stimulus(2'b00, sel, 1'b0, '0, 1'b0, 1'b1, 1'b0);
        apply_stimulus(2'b00, sel, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic check_obs(input int idx, input logic [DW-1:0] exp_data, input logic exp_done);
        if (idx < obs_data.size()) begin
            check_output($sformatf("word%0d_data", idx), obs_data[idx], exp_data);
            check_output($sformatf("word%0d_done", idx), obs_done[idx], exp_done);
        end else begin
            check_output($sformatf("word%0d_present", idx), obs_data.size(), idx + 1);
        end
    endtask

    task automatic clear_obs();
        obs_data.delete();
        obs_done.delete();
    endtask

    // Monitor: samples just after each rising edge, while inputs are steady.
    always @(posedge clk) begin
        #1;
        if (started) begin
            check_output("data_out", data_out, (current_state == 2'b11) ? 0 : m_hold);
            check_output("duration", duration, m_len[song_sel]);
            check_output("full", full, m_len[song_sel] == DEPTH);
            if (output_ready) begin
                if (exp_q.size() == 0) begin
                    check_output("unexpected_strobe", 1, 0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check_output("strobe_data", data_out, mon_e.data);
                    check_output("strobe_done", song_done, mon_e.done);
                    check_output("strobe_latency", edge_count, mon_e.due);
                    obs_data.push_back(data_out);
                    obs_done.push_back(song_done);
                end
            end else begin
                check_output("done_without_ready", song_done, 0);
                if (exp_q.size() > 0 && exp_q[0].due <= edge_count) begin
                    check_output("missing_strobe", 0, 1);
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        rst = 1'b1;
        apply_stimulus(2'b00, 0, 0, 0, 0, 0, 0);
        apply_stimulus(2'b00, 0, 0, 0, 0, 0, 0);
        rst = 1'b0;
        check_output("reset_ready", output_ready, 0);
        check_output("reset_done", song_done, 0);
        check_output("reset_data", data_out, 0);
        check_output("reset_duration", duration, 0);

        // Record 3,5,7 into slot 1, then play it without looping.
        foreach (obs_data[i]) obs_data[i] = '0;
        apply_stimulus(2'b11, 1, 1, 8'd3, 0, 0, 0);
        apply_stimulus(2'b11, 1, 1, 8'd5, 0, 0, 0);
        apply_stimulus(2'b11, 1, 1, 8'd7, 0, 0, 0);
        apply_stimulus(2'b11, 1, 0, 0, 0, 0, 0);
        check_output("rec_duration", duration, 3);
        apply_stimulus(2'b00, 1, 0, 0, 0, 0, 0);
        clear_obs();
        for (int i = 0; i < 5; i++) read_once(1);
        check_output("play_count", obs_data.size(), 3);
        check_obs(0, 8'd3, 0);
        check_obs(1, 8'd5, 0);
        check_obs(2, 8'd7, 1);

        // Looping playback.
        apply_stimulus(2'b00, 1, 0, 0, 0, 0, 1);
        loop_en = 1'b1;
        clear_obs();
        for (int i = 0; i < 5; i++) read_once(1);
        loop_en = 1'b0;
        check_output("loop_count", obs_data.size(), 5);
        check_obs(0, 8'd3, 0);
        check_obs(1, 8'd5, 0);
        check_obs(2, 8'd7, 1);
        check_obs(3, 8'd3, 0);
        check_obs(4, 8'd5, 0);

        // Slot switch mid-song.
        apply_stimulus(2'b11, 2, 1, 8'd9, 0, 0, 0);
        apply_stimulus(2'b00, 1, 0, 0, 0, 0, 0);
        clear_obs();
        read_once(1);
        apply_stimulus(2'b00, 2, 0, 0, 0, 0, 0);
        read_once(2);
        apply_stimulus(2'b00, 1, 0, 0, 0, 0, 0);
        read_once(1);
        check_output("switch_count", obs_data.size(), 3);
        check_obs(0, 8'd3, 0);
        check_obs(1, 8'd9, 1);
        check_obs(2, 8'd3, 0);

        // read_rst wins over a simultaneous read_en.
        apply_stimulus(2'b00, 1, 0, 0, 0, 0, 1);
        clear_obs();
        read_once(1);
        read_once(1);
        apply_stimulus(2'b00, 1, 0, 0, 0, 1, 1);
        apply_stimulus(2'b00, 1, 0, 0, 0, 0, 0);
        read_once(1);
        check_output("rewind_count", obs_data.size(), 3);
        check_obs(0, 8'd3, 0);
        check_obs(1, 8'd5, 0);
        check_obs(2, 8'd3, 0);

        // Fill slot 3 past capacity.
        for (int i = 0; i < 5; i++) begin
            apply_stimulus(2'b11, 3, 1, DW'(10 + i), 0, 0, 0);
            check_output($sformatf("fill%0d_duration", i), duration, (i < 4) ? i + 1 : 4);
            check_output($sformatf("fill%0d_full", i), full, i >= 3);
        end
        apply_stimulus(2'b00, 3, 0, 0, 0, 0, 0);
        clear_obs();
        for (int i = 0; i < 5; i++) read_once(3);
        check_output("full_count", obs_data.size(), 4);
        check_obs(3, 8'd13, 1);

        // clear beats write_en on slot 1.
        apply_stimulus(2'b11, 1, 1, 8'h55, 1, 0, 0);
        check_output("clear_duration", duration, 0);
        apply_stimulus(2'b00, 1, 0, 0, 0, 0, 0);
        clear_obs();
        read_once(1);
        read_once(1);
        check_output("empty_count", obs_data.size(), 0);

        // Reset while a word is in flight.
        apply_stimulus(2'b11, 0, 1, 8'd1, 0, 0, 0);
        apply_stimulus(2'b11, 0, 1, 8'd2, 0, 0, 0);
        apply_stimulus(2'b00, 0, 0, 0, 0, 0, 0);
        clear_obs();
        apply_stimulus(2'b00, 0, 0, 0, 0, 1, 0);
        rst = 1'b1;
        apply_stimulus(2'b00, 0, 0, 0, 0, 0, 0);
        rst = 1'b0;
        apply_stimulus(2'b00, 0, 0, 0, 0, 0, 0);
        check_output("rst_fetch_count", obs_data.size(), 0);
        check_output("rst_fetch_duration", duration, 0);

        // Random traffic against the model.
        for (int n = 0; n < 800; n++) begin
            logic [1:0]    st;
            logic [SB-1:0] sel;
            rst = ($urandom_range(0, 99) == 0);
            if ($urandom_range(0, 9) == 0) loop_en = $urandom_range(0, 1);
            st  = ($urandom_range(0, 9) < 3) ? 2'b11 : 2'($urandom_range(0, 2));
            if (n > 0 && $urandom_range(0, 9) != 0) st = current_state;
            sel = ($urandom_range(0, 9) == 0) ? SB'($urandom_range(0, SONGS - 1)) : song_sel;
            apply_stimulus(st, sel, $urandom_range(0, 1), DW'($urandom),
                           $urandom_range(0, 19) == 0, $urandom_range(0, 9) < 6,
                           $urandom_range(0, 19) == 0);
        end
        rst = 1'b0;
        for (int i = 0; i < 3; i++) apply_stimulus(2'b00, song_sel, 0, 0, 0, 0, 0);
        check_output("queue_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
